// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - packs FIFO bytes into wide words, emitting partial words on flush or idle timeout
// Optional build macro: PACKER_PARITY_EN adds per-lane even parity output out_par.
module fifo_word_packer #(
  parameter int WIDTH   = 8,
  parameter int BYTES   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [WIDTH-1:0]       fifo_dout,
  input  logic                   flush,
  output logic [WIDTH*BYTES-1:0] out_data,
  output logic [3:0]             out_bytes,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef PACKER_PARITY_EN
  output logic [BYTES-1:0]       out_par,
`endif
  output logic                   busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT - 1);
  localparam logic [3:0]    CNT_FULL = 4'(BYTES);

  typedef enum logic [1:0] {IDLE, READ, CAPT, SEND} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   flush_pend_q, flush_pend_d;
  logic [WIDTH*BYTES-1:0] data_q, data_d;
`ifdef PACKER_PARITY_EN
  logic [BYTES-1:0]       par_q, par_d;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      tmo_q        <= '0;
      flush_pend_q <= 1'b0;
      data_q       <= '0;
`ifdef PACKER_PARITY_EN
      par_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      flush_pend_q <= flush_pend_d;
      data_q       <= data_d;
`ifdef PACKER_PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    flush_pend_d = flush_pend_q;
    data_d       = data_q;
`ifdef PACKER_PARITY_EN
    par_d        = par_q;
`endif
    // A flush seen while busy is remembered until the word carrying it is accepted.
    if (flush && (state_q != IDLE)) flush_pend_d = 1'b1;

    case (state_q)
      IDLE: begin
        if ((flush || flush_pend_q) && (cnt_q != 4'd0)) state_d = SEND;
        else if ((tmo_q == TMO_MAX) && (cnt_q != 4'd0)) state_d = SEND;
        else if (!fifo_empty)                            state_d = READ;
        if ((cnt_q != 4'd0) && fifo_empty && (tmo_q != TMO_MAX)) tmo_d = tmo_q + TW'(1);
      end
      READ: begin
        tmo_d   = '0;
        state_d = CAPT;
      end
      CAPT: begin
        for (int i = 0; i < BYTES; i++) begin
          if (cnt_q == 4'(i)) begin
            data_d[i*WIDTH +: WIDTH] = fifo_dout;
`ifdef PACKER_PARITY_EN
            par_d[i] = ^fifo_dout;
`endif
          end
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q + 4'd1 == CNT_FULL) state_d = SEND;
        else if (flush_pend_q)        state_d = SEND;
        else if (!fifo_empty)         state_d = READ;
        else                          state_d = IDLE;
      end
      SEND: begin
        if (out_ready) begin
          cnt_d        = '0;
          tmo_d        = '0;
          data_d       = '0;
          flush_pend_d = 1'b0;
`ifdef PACKER_PARITY_EN
          par_d        = '0;
`endif
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo_rd_en = (state_q == READ);
  assign out_valid  = (state_q == SEND);
  assign out_bytes  = out_valid ? cnt_q : 4'd0;
  assign out_data   = data_q;
  assign busy       = (state_q != IDLE) || (cnt_q != 4'd0);
`ifdef PACKER_PARITY_EN
  assign out_par    = par_q;
`endif

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - directed and randomized bench for fifo_word_packer with a queue-based FIFO and word model
`timescale 1ns/1ps
module tb_fifo_word_packer;
  localparam int WIDTH = 8, BYTES = 4, TIMEOUT = 16;

  logic        clk = 1'b0, rst = 1'b0, fifo_empty = 1'b1, flush = 1'b0, out_ready = 1'b0;
  logic        fifo_rd_en, out_valid, busy;
  logic [7:0]  fifo_dout = 8'h00;
  logic [31:0] out_data;
  logic [3:0]  out_bytes;
`ifdef PACKER_PARITY_EN
  logic [3:0]  out_par;
  logic [3:0]  rx_par[$];
`endif

  int          tests = 0, fails = 0, cyc = 0;
  byte unsigned fifo_q[$], sent_q[$], pend_q[$];
  int          rd_log[$];
  logic [31:0] rx_data[$];
  logic [3:0]  rx_bytes[$];
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [35:0] prev_word = '0;

  fifo_word_packer #(.WIDTH(WIDTH), .BYTES(BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .flush(flush), .out_data(out_data), .out_bytes(out_bytes),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef PACKER_PARITY_EN
    .out_par(out_par),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(byte unsigned b[$], int base, int n);
    logic [31:0] w = '0;
    for (int j = 0; j < n; j++) w = w | (32'(b[base+j]) << (8*j));
    return w;
  endfunction

  function automatic logic [3:0] lane_par(logic [31:0] w, int n);
    logic [3:0] p = '0;
    for (int j = 0; j < n; j++) p[j] = ^w[8*j +: 8];
    return p;
  endfunction

  task automatic push(byte unsigned b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample pre-edge outputs, then model the FIFO pop on the edge.
  task automatic tick();
    logic rd;
    rd = fifo_rd_en;
    check("rd_en_while_empty", 64'(rd & fifo_empty), 64'd0);
    if (rd) rd_log.push_back(cyc);
    if (out_valid && out_ready) begin
      rx_data.push_back(out_data);
      rx_bytes.push_back(out_bytes);
`ifdef PACKER_PARITY_EN
      rx_par.push_back(out_par);
`endif
    end
    prev_valid = out_valid;
    prev_ready = out_ready;
    prev_word  = {out_bytes, out_data};
    @(posedge clk);
    #1;
    cyc++;
    if (rd && fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
    if (prev_valid && !prev_ready) begin
      check("valid_hold", 64'(out_valid), 64'd1);
      check("word_hold", 64'({out_bytes, out_data}), 64'(prev_word));
    end
  endtask

  task automatic wait_valid(string tag, int bound);
    int n = 0;
    while (!out_valid && n < bound) begin
      tick();
      n++;
    end
    check(tag, 64'(out_valid), 64'd1);
  endtask

  initial begin
    int n, k, gap;
    byte unsigned b;

    // Reset state
    #12;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_bytes", 64'(out_bytes), 64'd0);
    check("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Full word, pops two cycles apart
    out_ready = 1'b1;
    rd_log.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid("full_valid", 40);
    check("full_data", 64'(out_data), 64'h44332211);
    check("full_bytes", 64'(out_bytes), 64'd4);
    check("full_rd_count", 64'(rd_log.size()), 64'd4);
    for (int i = 1; i < 4 && i < rd_log.size(); i++)
      check("full_rd_spacing", 64'(rd_log[i] - rd_log[i-1]), 64'd2);
    tick();
    check("full_valid_one_cycle", 64'(out_valid), 64'd0);

    // Backpressure: word held, no pops while waiting
    out_ready = 1'b0;
    rd_log.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_valid("bp_valid", 40);
    push(8'h55);
    repeat (10) tick();
    check("bp_no_pop", 64'(rd_log.size()), 64'd4);
    check("bp_still_valid", 64'(out_valid), 64'd1);
    check("bp_data", 64'(out_data), 64'h44332211);
    out_ready = 1'b1;
    tick();
    check("bp_released", 64'(out_valid), 64'd0);
    wait_valid("bp_next_valid", 60);
    check("bp_next_data", 64'(out_data), 64'h00000055);
    check("bp_next_bytes", 64'(out_bytes), 64'd1);
    check("bp_next_pops", 64'(rd_log.size()), 64'd5);
    tick();

    // Idle timeout emits a partial word
    rd_log.delete();
    push(8'hAA); push(8'hBB);
    wait_valid("tmo_valid", 60);
    check("tmo_data", 64'(out_data), 64'h0000BBAA);
    check("tmo_bytes", 64'(out_bytes), 64'd2);
    if (rd_log.size() == 2) check("tmo_latency", 64'(cyc - rd_log[1]), 64'(TIMEOUT + 2));
    else check("tmo_pop_count", 64'(rd_log.size()), 64'd2);
    tick();

    // Flush during READ
    push(8'h01);
    n = 0;
    while (!fifo_rd_en && n < 5) begin tick(); n++; end
    check("flush_reached_read", 64'(fifo_rd_en), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_capt_not_valid", 64'(out_valid), 64'd0);
    tick();
    check("flush_valid", 64'(out_valid), 64'd1);
    check("flush_data", 64'(out_data), 64'h00000001);
    check("flush_bytes", 64'(out_bytes), 64'd1);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (3) tick();
    check("flush_empty_no_word", 64'(out_valid), 64'd0);
    check("flush_empty_not_busy", 64'(busy), 64'd0);

    // Asynchronous reset during CAPT with two bytes held
    rd_log.delete();
    push(8'hC0); push(8'hC1); push(8'hC2);
    n = 0;
    while (!(rd_log.size() == 2 && fifo_rd_en) && n < 20) begin tick(); n++; end
    tick();
    check("rst_mid_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_data", 64'(out_data), 64'd0);
    check("rst_mid_bytes", 64'(out_bytes), 64'd0);
    check("rst_mid_rd_en", 64'(fifo_rd_en), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    fifo_q.delete();
    fifo_empty = 1'b1;
    prev_valid = 1'b0;
    push(8'h10); push(8'h11); push(8'h12); push(8'h13);
    wait_valid("rst_after_valid", 40);
    check("rst_after_data", 64'(out_data), 64'h13121110);
    check("rst_after_bytes", 64'(out_bytes), 64'd4);
    tick();

`ifdef PACKER_PARITY_EN
    push(8'h01); push(8'h03); push(8'h07); push(8'h00);
    wait_valid("par_valid", 40);
    check("par_lanes", 64'(out_par), 64'b0101);
    tick();
    check("par_cleared", 64'(out_par), 64'd0);
`endif

    // Randomized full words under random backpressure
    rx_data.delete(); rx_bytes.delete();
`ifdef PACKER_PARITY_EN
    rx_par.delete();
`endif
    sent_q.delete();
    for (int i = 0; i < 30 * BYTES; i++) begin
      b = 8'($urandom);
      pend_q.push_back(b);
      sent_q.push_back(b);
    end
    gap = 0;
    n = 0;
    while ((pend_q.size() > 0 || rx_data.size() < 30) && n < 5000) begin
      out_ready = 1'($urandom_range(0, 1));
      if (pend_q.size() > 0 && ($urandom_range(0, 1) == 1 || gap >= 5)) begin
        push(pend_q.pop_front());
        gap = 0;
      end else gap++;
      tick();
      n++;
    end
    out_ready = 1'b1;
    check("rand_word_count", 64'(rx_data.size()), 64'd30);
    for (int i = 0; i < rx_data.size() && i < 30; i++) begin
      check("rand_data", 64'(rx_data[i]), 64'(pack(sent_q, i*BYTES, BYTES)));
      check("rand_bytes", 64'(rx_bytes[i]), 64'd4);
`ifdef PACKER_PARITY_EN
      check("rand_par", 64'(rx_par[i]), 64'(lane_par(rx_data[i], BYTES)));
`endif
    end

    // Randomized partial word via timeout
    sent_q.delete();
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) begin
      b = 8'($urandom);
      sent_q.push_back(b);
      push(b);
    end
    wait_valid("rand_tmo_valid", 80);
    check("rand_tmo_data", 64'(out_data), 64'(pack(sent_q, 0, k)));
    check("rand_tmo_bytes", 64'(out_bytes), 64'(k));
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
